// File: rtl/stopwatch_ssd.sv
// Minutes:seconds BCD stopwatch (00:00-59:59) driving a four-digit,
// active-low seven-segment display scanned by an external divider.
module stopwatch_ssd #(
    parameter bit WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_1hz_in,
    input  logic [1:0]  clk_ctl,
    input  logic        btn_start,
    input  logic        btn_clear,
    output logic [3:0]  ssd_ctl,
    output logic [7:0]  segs,
    output logic        running,
    output logic [15:0] digits
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        prev;
    logic        tick;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic [3:0]  ssd_ctl_n;
    logic [3:0]  digit_sel;
    logic [7:0]  seg_code;
    logic        dp_n;

    assign tick    = clk_1hz_in & ~prev;
    assign running = (state == ST_RUN);
    assign digits  = cnt;

    // BCD ripple increment; 59:59 naturally rolls over to 00:00
    always_comb begin
        cnt_inc = cnt;
        if (cnt[3:0] != 4'd9) begin
            cnt_inc[3:0] = cnt[3:0] + 4'd1;
        end else begin
            cnt_inc[3:0] = 4'd0;
            if (cnt[7:4] != 4'd5) begin
                cnt_inc[7:4] = cnt[7:4] + 4'd1;
            end else begin
                cnt_inc[7:4] = 4'd0;
                if (cnt[11:8] != 4'd9) begin
                    cnt_inc[11:8] = cnt[11:8] + 4'd1;
                end else begin
                    cnt_inc[11:8] = 4'd0;
                    if (cnt[15:12] != 4'd5) cnt_inc[15:12] = cnt[15:12] + 4'd1;
                    else                    cnt_inc[15:12] = 4'd0;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_STOP: begin
                if (btn_clear) cnt_n   = '0;
                if (btn_start) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (btn_clear) begin
                    cnt_n = '0;
                end else if (tick) begin
                    if (cnt == 16'h5959 && !WRAP) state_n = ST_DONE;
                    else                          cnt_n   = cnt_inc;
                end
                if (btn_start) state_n = ST_STOP;
            end
            ST_DONE: begin
                if (btn_clear) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                end
            end
            default: state_n = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
            cnt   <= '0;
            prev  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            prev  <= clk_1hz_in;
        end
    end

    always_comb begin
        case (clk_ctl)
            2'b00:   begin ssd_ctl_n = 4'b1110; digit_sel = cnt[3:0];   end
            2'b01:   begin ssd_ctl_n = 4'b1101; digit_sel = cnt[7:4];   end
            2'b10:   begin ssd_ctl_n = 4'b1011; digit_sel = cnt[11:8];  end
            default: begin ssd_ctl_n = 4'b0111; digit_sel = cnt[15:12]; end
        endcase
        case (digit_sel)
            4'd0:    seg_code = 8'h03;
            4'd1:    seg_code = 8'h9F;
            4'd2:    seg_code = 8'h25;
            4'd3:    seg_code = 8'h0D;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h49;
            4'd6:    seg_code = 8'h41;
            4'd7:    seg_code = 8'h1F;
            4'd8:    seg_code = 8'h01;
            4'd9:    seg_code = 8'h09;
            default: seg_code = 8'hFF;
        endcase
        // colon is the min_ones decimal point, blinking with the slow clock
        dp_n = ~((clk_ctl == 2'b10) & running & clk_1hz_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_ctl <= '1;
            segs    <= '1;
        end else begin
            ssd_ctl <= ssd_ctl_n;
            segs    <= {seg_code[7:1], dp_n};
        end
    end

endmodule

// File: doc/stopwatch_ssd.md
# stopwatch_ssd

Minutes:seconds stopwatch (00:00–59:59, BCD) with four-digit seven-segment scan output. Consumes the divided slow clock (`clk_1hz_in`, period 2^27 `clk` cycles) and the 2-bit scan select (`clk_ctl`) produced by the frequency divider in the same `clk` domain. Takes single-cycle debounced button pulses for start/stop and clear. Drives the board's active-low digit enables and segment lines directly.

## Interface
- `WRAP`, default 1: 1 = roll 59:59 → 00:00 and keep running; 0 = hold at 59:59 and enter DONE.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_1hz_in`  in  1  divided slow clock, synchronous to `clk`, level signal.
- `clk_ctl`  in  2  digit scan select from the divider.
- `btn_start`  in  1  one-`clk` pulse; toggles run/stop.
- `btn_clear`  in  1  one-`clk` pulse; zeroes the count.
- `ssd_ctl`  out  4  active-low digit enables; bit 0 is the rightmost digit.
- `segs`  out  8  active-low `{a,b,c,d,e,f,g,dp}`.
- `running`  out  1  high in RUN.
- `digits`  out  16  BCD `{min_tens, min_ones, sec_tens, sec_ones}`.

## Operation
- Tick detect: `prev` register samples `clk_1hz_in`. `tick = clk_1hz_in & ~prev`, giving one `clk` cycle per slow-clock rising edge.
- States:
  - STOP (reset state).
  - RUN.
  - DONE (reachable only when WRAP=0).
- STOP:
  - `btn_start` → RUN.
  - `btn_clear` → count = 0000, stay in STOP.
  - Ticks are ignored.
- RUN:
  - `tick` → increment the count.
  - `btn_start` → STOP. A tick in the same cycle still increments.
  - `btn_clear` → count = 0000, stay in RUN. Clear beats a tick in the same cycle.
  - Start and clear together → count 0000 and state STOP.
- Increment is a BCD ripple:
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_ones`.
  - `min_ones` 9→0 carries into `min_tens`.
  - `min_tens` 5→0.
  - Digits are never outside 0–9 (tens ≤ 5).
- At 59:59 with a tick:
  - WRAP=1 → 00:00, stay in RUN.
  - WRAP=0 → count holds 59:59, go to DONE.
- DONE:
  - `btn_start` is ignored.
  - `btn_clear` → count 0000 and STOP.
  - Ticks are ignored.
- Scan, by `clk_ctl`:
  - 00 → `ssd_ctl` = 1110, shows `sec_ones`.
  - 01 → `ssd_ctl` = 1101, shows `sec_tens`.
  - 10 → `ssd_ctl` = 1011, shows `min_ones`.
  - 11 → `ssd_ctl` = 0111, shows `min_tens`.
- Segment codes (dp off, hex): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09.
- Decimal point: `dp` (bit 0) is driven 0 only on the `min_ones` digit, when `running` = 1 and `clk_1hz_in` = 1. The colon blinks while running and is steady off otherwise.

## Timing
- Reset values (asynchronous):
  - `ssd_ctl` = 1111, `segs` = FF, `running` = 0, `digits` = 0000.
  - `prev` = 0, state STOP.
- A `clk_1hz_in` level that is already high at reset release yields a tick while in STOP, which is ignored.
- Tick latency: in the cycle where `clk_1hz_in` first reads 1, `digits` updates on that cycle's closing edge, i.e. visible 1 cycle after the rise is sampled.
- Button latency: `running` and state change on the edge that samples the pulse.
- Display latency:
  - `ssd_ctl` and `segs` are registered, one cycle after `clk_ctl` or `digits` change.
  - There is no blanking cycle. The enable and segments always switch on the same edge.
- `btn_start` or `btn_clear` held for more than 1 cycle is a caller violation: each high cycle acts as a separate pulse.
- A reset asserted mid-count forces all reset values immediately. The count is not retained.

## Test plan
- Reset with `clk_ctl` = 00 → `ssd_ctl` = 1110 and `segs` = 03 one cycle after release; `running` = 0. Ten `clk_1hz_in` edges leave `digits` = 0000.
- Start pulse, then 75 slow edges → `digits` = 0115. While `clk_ctl` = 10 and `clk_1hz_in` = 1, `segs` = 9E (1 with dp lit).
- Preload to 09:59 via 599 ticks, then one more tick → 10:00 (checks the full carry chain). Clear plus tick in the same cycle → 0000, still RUN.
- WRAP=1 at 59:59 + tick → 00:00, `running` = 1. WRAP=0 → hold 5959 in DONE. Start is ignored; clear → 0000 and `running` = 0.
- Start pulse coincident with a tick in RUN → count +1 and `running` = 0. Subsequent ticks produce no change.
- Cycle `clk_ctl` 00→11 with `digits` = 3704 → (`ssd_ctl`, `segs`) = (1110, 99), (1101, 03), (1011, 1F), (0111, 0D), each one cycle delayed.
